// File: rtl/fft_pkg.sv
// Shared sizes, FSM state type and bus-slot helper for the 16-point radix-4 FFT sequencer.
package fft_pkg;

    localparam int DW  = 17;
    localparam int NPT = 16;
    localparam int CW  = 2 * DW;
    localparam int BW  = 4 * CW;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_S1     = 2'd1,
        ST_S2     = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    // Slot s of a 4-word butterfly bus lives at bits [34s+33:34s].
    function automatic logic [CW-1:0] slot_get(input logic [BW-1:0] bus, input int s);
        return bus[CW*s +: CW];
    endfunction

endpackage

// File: rtl/fft16_bank.sv
// 16x34 register file: one streaming write, one strided 4-word gather, one 4-word scatter.
module fft16_bank
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [3:0]    wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic [1:0]    ga_base,
    output logic [BW-1:0] ga_data,
    input  logic          sc_en,
    input  logic [1:0]    sc_base,
    input  logic          sc_strided,
    input  logic [BW-1:0] sc_data
);

    logic [CW-1:0] mem [NPT];

    // Gather slot s reads word base + 4s.
    always_comb begin
        ga_data = '0;
        for (int s = 0; s < 4; s++) begin
            ga_data[CW*s +: CW] = mem[{2'(s), ga_base}];
        end
    end

    // Scatter slot k goes to base + 4k (strided) or 4*base + k (contiguous).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (sc_en) begin
            for (int k = 0; k < 4; k++) begin
                if (sc_strided) begin
                    mem[{2'(k), sc_base}] <= slot_get(sc_data, k);
                end else begin
                    mem[{sc_base, 2'(k)}] <= slot_get(sc_data, k);
                end
            end
        end
    end

endmodule

// File: rtl/fft16_radix4_sequencer.sv
// Frame controller for a 16-point radix-4 DIT FFT around one external shared butterfly:
// load 16 samples, run 8 two-cycle butterfly ops across two banks, stream results out.
module fft16_radix4_sequencer
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_data,
    output logic          out_last,
    output logic [BW-1:0] bf_calc_in,
    output logic [2:0]    bf_rotation,
    input  logic [BW-1:0] bf_calc_out,
    output logic          busy,
    output logic          frame_done
);

    state_t        state;
    logic [3:0]    in_cnt;
    logic [3:0]    out_cnt;
    logic [2:0]    op;
    logic          ex;
    logic [BW-1:0] a_ga;
    logic [BW-1:0] b_ga;
    logic [1:0]    a_base;
    logic          in_hs;
    logic          out_hs;

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_UNLOAD);
    assign busy      = (state == ST_S1) || (state == ST_S2);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // During unload the gather port doubles as the output read: A[out_cnt] is slot out_cnt[3:2].
    assign a_base   = (state == ST_UNLOAD) ? out_cnt[1:0] : op[1:0];
    assign out_data = slot_get(a_ga, int'(out_cnt[3:2]));
    assign out_last = out_valid && (out_cnt == 4'd15);

    fft16_bank u_bank_a (
        .clk        (clk),
        .wr_en      (in_hs),
        .wr_addr    (in_cnt),
        .wr_data    (in_data),
        .ga_base    (a_base),
        .ga_data    (a_ga),
        .sc_en      ((state == ST_S2) && ex),
        .sc_base    (op[1:0]),
        .sc_strided (1'b1),
        .sc_data    (bf_calc_out)
    );

    fft16_bank u_bank_b (
        .clk        (clk),
        .wr_en      (1'b0),
        .wr_addr    (4'd0),
        .wr_data    ({CW{1'b0}}),
        .ga_base    (op[1:0]),
        .ga_data    (b_ga),
        .sc_en      ((state == ST_S1) && ex),
        .sc_base    (op[1:0]),
        .sc_strided (1'b0),
        .sc_data    (bf_calc_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            in_cnt      <= 4'd0;
            out_cnt     <= 4'd0;
            op          <= 3'd0;
            ex          <= 1'b0;
            frame_done  <= 1'b0;
            bf_calc_in  <= '0;
            bf_rotation <= 3'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_hs) begin
                        in_cnt <= in_cnt + 4'd1;
                        if (in_cnt == 4'd15) begin
                            state <= ST_S1;
                        end
                    end
                end
                ST_S1, ST_S2: begin
                    // RD cycle registers the operands; the EX cycle's edge captures the results.
                    if (!ex) begin
                        bf_calc_in  <= (state == ST_S1) ? a_ga : b_ga;
                        bf_rotation <= op;
                        ex          <= 1'b1;
                    end else begin
                        ex <= 1'b0;
                        op <= op + 3'd1;
                        if (op == 3'd3) begin
                            state <= ST_S2;
                        end
                        if (op == 3'd7) begin
                            state <= ST_UNLOAD;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (out_hs) begin
                        out_cnt <= out_cnt + 4'd1;
                        if (out_cnt == 4'd15) begin
                            state      <= ST_LOAD;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft16_radix4_sequencer.sv
// Directed bench for fft16_radix4_sequencer with a pass-through or integer radix-4 butterfly model.
module tb_fft16_radix4_sequencer;
    import fft_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_data;
    logic          out_last;
    logic [BW-1:0] bf_calc_in;
    logic [2:0]    bf_rotation;
    logic [BW-1:0] bf_calc_out;
    logic          busy;
    logic          frame_done;

    bit real_mode = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int t_last = 0;
    int x_re[16], x_im[16], y_re[16], y_im[16];
    int got_re[16], got_im[16];
    bit got_last[16];

    localparam int COSQ[10] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137, -16384, -15137};
    localparam int SINQ[10] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270, 0, -6270};
    localparam int COSX[16] = '{64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59};
    localparam bit PAT[8]   = '{1, 0, 0, 1, 1, 0, 1, 0};

    fft16_radix4_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .bf_calc_in  (bf_calc_in),
        .bf_rotation (bf_rotation),
        .bf_calc_out (bf_calc_out),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Twiddle W16^(p*s) on slot s for stage-2 ops, then a plain 4-point DFT (Q14 twiddles).
    function automatic logic [BW-1:0] bf_model(input logic [BW-1:0] ci, input logic [2:0] rot, input bit rm);
        int tr[4];
        int ti[4];
        int a, b, e, p;
        int xr, xi;
        logic [BW-1:0] r;
        r = '0;
        if (!rm) return ci;
        p = rot[2] ? int'(rot[1:0]) : 0;
        for (int s = 0; s < 4; s++) begin
            a = $signed(ci[CW*s+DW +: DW]);
            b = $signed(ci[CW*s +: DW]);
            e = p * s;
            tr[s] = (a * COSQ[e] + b * SINQ[e] + 8192) >>> 14;
            ti[s] = (b * COSQ[e] - a * SINQ[e] + 8192) >>> 14;
        end
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin xr = tr[0] + tr[1] + tr[2] + tr[3]; xi = ti[0] + ti[1] + ti[2] + ti[3]; end
                1: begin xr = tr[0] + ti[1] - tr[2] - ti[3]; xi = ti[0] - tr[1] - ti[2] + tr[3]; end
                2: begin xr = tr[0] - tr[1] + tr[2] - tr[3]; xi = ti[0] - ti[1] + ti[2] - ti[3]; end
                default: begin xr = tr[0] - ti[1] - tr[2] + ti[3]; xi = ti[0] + tr[1] - ti[2] - tr[3]; end
            endcase
            r[CW*k +: CW] = {17'(xr), 17'(xi)};
        end
        return r;
    endfunction

    always_comb bf_calc_out = bf_model(bf_calc_in, bf_rotation, real_mode);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 400000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int near(input int got, input int exp, input int tol);
        return (got - exp <= tol && exp - got <= tol) ? exp : got;
    endfunction

    function automatic int perm(input int n);
        return (n >> 2) + 4 * (n & 3);
    endfunction

    function automatic logic [CW-1:0] w(input int re, input int im);
        return {17'(re), 17'(im)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        for (int i = 0; i < 16; i++) begin
            int guard = 0;
            in_valid = 1'b1;
            in_data  = w(x_re[i], x_im[i]);
            while (!in_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (!in_ready) chk("load_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        t_last = cyc;
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, k, 16);
    endtask

    task automatic unload(input bit bp, input string tag);
        int i = 0;
        int guard = 0;
        int pc = 0;
        bit stalled = 1'b0;
        logic [CW:0] held = '0;
        while (i < 16 && guard < 400) begin
            bit r;
            r = bp ? PAT[pc % 8] : 1'b1;
            pc++;
            out_ready = r;
            if (out_valid) begin
                if (stalled) chk({tag, "_stall_hold"}, {out_last, out_data}, held);
                if (i == 8) chk({tag, "_in_ready_lo"}, in_ready, 0);
                if (r) begin
                    got_re[i]   = $signed(out_data[CW-1:DW]);
                    got_im[i]   = $signed(out_data[DW-1:0]);
                    got_last[i] = out_last;
                    i++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {out_last, out_data};
                end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        if (i < 16) chk({tag, "_unload_timeout"}, i, 16);
        chk({tag, "_frame_done"}, frame_done, 1);
        chk({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_bf_calc_in", bf_calc_in, 0);
        chk("rst_bf_rotation", bf_rotation, 0);

        // Pass-through ramp with op trace
        for (int n = 0; n < 16; n++) begin x_re[n] = n; x_im[n] = 0; end
        load_frame();
        for (int c = 0; c <= 16; c++) begin
            if (c == 1) chk("op0_slots", bf_calc_in, {w(12, 0), w(8, 0), w(4, 0), w(0, 0)});
            if (c == 11) chk("op5_slots", bf_calc_in, {w(7, 0), w(6, 0), w(5, 0), w(4, 0)});
            if (c % 2 == 1) chk("rot_ex", bf_rotation, (c - 1) / 2);
            if (c == 8) chk("busy_mid", busy, 1);
            if (c == 15) chk("ovalid_early", out_valid, 0);
            if (c < 16) tick();
        end
        chk("ovalid_T17", out_valid, 1);
        unload(1'b0, "ramp");
        for (int n = 0; n < 16; n++) begin
            chk("ramp_re", got_re[n], perm(n));
            chk("ramp_im", got_im[n], 0);
            chk("ramp_last", got_last[n], (n == 15));
        end
        tick();
        chk("ramp_fd_off", frame_done, 0);
        chk("ramp_fd_count", fd_cnt, 1);

        // Real butterfly: impulse
        real_mode = 1'b1;
        for (int n = 0; n < 16; n++) begin x_re[n] = 0; x_im[n] = 0; end
        x_re[0] = 64;
        load_frame();
        wait_out("imp");
        unload(1'b0, "imp");
        for (int n = 0; n < 16; n++) begin
            chk("imp_re", near(got_re[n], 64, 2), 64);
            chk("imp_im", near(got_im[n], 0, 2), 0);
        end
        tick();

        // Real butterfly: cosine at bin 1, with backpressure
        for (int n = 0; n < 16; n++) begin x_re[n] = COSX[n]; x_im[n] = 0; end
        load_frame();
        wait_out("cos");
        unload(1'b1, "cos");
        for (int n = 0; n < 16; n++) begin
            int er;
            er = (n == 1 || n == 15) ? 512 : 0;
            chk("cos_re", near(got_re[n], er, 10), er);
            chk("cos_im", near(got_im[n], 0, 10), 0);
        end
        tick();

        // Reset during stage 2 op 5, then a clean frame
        real_mode = 1'b0;
        for (int n = 0; n < 16; n++) begin x_re[n] = 3 * n + 1; x_im[n] = -n; end
        load_frame();
        repeat (10) tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_rotation", bf_rotation, 0);
        repeat (20) tick();
        chk("abort_no_output", out_valid, 0);
        chk("abort_fd_count", fd_cnt, 3);
        load_frame();
        wait_out("rcv");
        unload(1'b1, "rcv");
        for (int n = 0; n < 16; n++) begin
            chk("rcv_re", got_re[n], x_re[perm(n)]);
            chk("rcv_im", got_im[n], x_im[perm(n)]);
        end
        tick();

        // Back-to-back frames with in_valid held high
        for (int n = 0; n < 16; n++) begin
            x_re[n] = n + 20; x_im[n] = 2 * n;
            y_re[n] = -n - 1; y_im[n] = 5 * n;
        end
        load_frame();
        in_valid = 1'b1;
        in_data  = w(y_re[0], y_im[0]);
        wait_out("b2b1");
        unload(1'b0, "b2b1");
        for (int n = 0; n < 16; n++) begin
            chk("b2b1_re", got_re[n], x_re[perm(n)]);
            chk("b2b1_im", got_im[n], x_im[perm(n)]);
        end
        for (int n = 0; n < 16; n++) begin x_re[n] = y_re[n]; x_im[n] = y_im[n]; end
        begin
            int c0;
            c0 = cyc;
            load_frame();
            chk("b2b_load_cycles", t_last - c0, 16);
        end
        wait_out("b2b2");
        unload(1'b0, "b2b2");
        for (int n = 0; n < 16; n++) begin
            chk("b2b2_re", got_re[n], x_re[perm(n)]);
            chk("b2b2_im", got_im[n], x_im[perm(n)]);
        end
        tick();
        chk("final_fd_off", frame_done, 0);
        chk("final_fd_count", fd_cnt, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
